// File: rtl/adder_tree_pkg.sv
// Shared constants and types for the adder tree and its operand loader.
package adder_tree_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 128;
    localparam int unsigned DEF_NUM_OPERANDS = 8;

    // Count width must hold NUM_OPERANDS itself, hence the extra bit.
    function automatic int unsigned cnt_w(input int unsigned num_operands);
        return $clog2(num_operands) + 1;
    endfunction

    typedef enum logic {
        FILL    = 1'b0,
        PRESENT = 1'b1
    } loader_state_e;

endpackage

// File: rtl/adder_tree_operand_loader.sv
// Packs a valid/ready operand stream into a zero-padded parallel group
// for the adder tree input register.
module adder_tree_operand_loader
    import adder_tree_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter  int unsigned NUM_OPERANDS = DEF_NUM_OPERANDS,
    localparam int unsigned CNT_W        = cnt_w(NUM_OPERANDS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              in_data,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_OPERANDS*DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]                   out_count
);

    localparam int unsigned IDX_W = $clog2(NUM_OPERANDS);

    loader_state_e state;
    loader_state_e state_d;

    logic [CNT_W-1:0] wr_idx;
    logic [CNT_W-1:0] wr_idx_d;
    logic [CNT_W-1:0] count_d;
    logic             valid_d;
    logic             take;
    logic             wr_en;
    logic             clear;

    logic [NUM_OPERANDS-1:0][DATA_WIDTH-1:0] bank;

    assign in_ready = (state == FILL) && !rst;
    assign take     = in_valid && in_ready;
    assign out_data = bank;

    // Next-state, write-enable and group-release decode.
    always_comb begin
        state_d  = state;
        wr_idx_d = wr_idx;
        count_d  = out_count;
        valid_d  = out_valid;
        wr_en    = 1'b0;
        clear    = 1'b0;
        case (state)
            FILL: begin
                if (take) begin
                    wr_en    = 1'b1;
                    wr_idx_d = CNT_W'(wr_idx + 1'b1);
                    if ((wr_idx == CNT_W'(NUM_OPERANDS - 1)) || in_last) begin
                        state_d = PRESENT;
                        valid_d = 1'b1;
                        count_d = CNT_W'(wr_idx + 1'b1);
                    end
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    state_d  = FILL;
                    valid_d  = 1'b0;
                    wr_idx_d = '0;
                    count_d  = '0;
                    clear    = 1'b1;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            wr_idx    <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            wr_idx    <= wr_idx_d;
            out_count <= count_d;
            out_valid <= valid_d;
        end
    end

    // Slots are wiped on release so a short next group reads zero padding.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bank <= '0;
        end else if (wr_en) begin
            bank[wr_idx[IDX_W-1:0]] <= in_data;
        end
    end

endmodule
